branch_resolve_predictor: RTL and testbench

Sits at both ends of the ID/EX pipeline register. In ID it supplies the taken/not-taken prediction (branch_predict_d) for a decoded branch. In EX it takes the registered branch, operands, prediction and not-chosen PC, and resolves the branch. On a misprediction it raises the flush that clears IF/ID and ID/EX and supplies the redirect PC. It holds a PC-indexed table of 2-bit saturating counters and two performance counters.

---
 rtl/branch_resolve_predictor.sv | 91 +++++++++
 tb/tb_branch_resolve_predictor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_predictor.sv
// Branch predictor and resolver spanning the ID/EX boundary: a PC-indexed table of
// 2-bit saturating counters, same-cycle mispredict flush, and resolve statistics.
module branch_resolve_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_d,
    input  logic        branch_d,
    output logic        predict_o,
    input  logic        branch_e,
    input  logic        branch_predict_e,
    input  logic [31:0] pc_e,
    input  logic [31:0] rs1_e,
    input  logic [31:0] rs2_e,
    input  logic [31:0] pc_notchosen_e,
    output logic        flush_o,
    output logic [31:0] redirect_pc_o,
    input  logic        stat_clr,
    output logic [31:0] branch_cnt_o,
    output logic [31:0] mispredict_cnt_o
);

    logic [1:0]       table_r [ENTRIES];
    logic [IDX_W-1:0] idx_d_s;
    logic [IDX_W-1:0] idx_e_s;
    logic             taken_s;
    logic             mispredict_s;
    logic [31:0]      branch_cnt_r;
    logic [31:0]      mispredict_cnt_r;

    // Saturating step of a 2-bit counter toward taken (up) or not-taken (down).
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            if (ctr == 2'b11) begin
                nxt = 2'b11;
            end else begin
                nxt = ctr + 2'b01;
            end
        end else begin
            if (ctr == 2'b00) begin
                nxt = 2'b00;
            end else begin
                nxt = ctr - 2'b01;
            end
        end
        return nxt;
    endfunction

    // Lookup and resolve are combinational so the flush lands on the same edge.
    always_comb begin
        idx_d_s       = pc_d[IDX_W+1:2];
        idx_e_s       = pc_e[IDX_W+1:2];
        taken_s       = (rs1_e == rs2_e);
        mispredict_s  = branch_e & (taken_s != branch_predict_e);
        predict_o     = branch_d & table_r[idx_d_s][1];
        flush_o       = mispredict_s;
        redirect_pc_o = pc_notchosen_e;
    end

    // History table: reset to weak-taken, trained by every resolved branch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= 2'b10;
            end
        end else if (branch_e) begin
            table_r[idx_e_s] <= ctr_next(table_r[idx_e_s], taken_s);
        end
    end

    // Performance counters; clear wins over a same-cycle increment, both wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt_r     <= 32'd0;
            mispredict_cnt_r <= 32'd0;
        end else if (stat_clr) begin
            branch_cnt_r     <= 32'd0;
            mispredict_cnt_r <= 32'd0;
        end else begin
            branch_cnt_r     <= branch_cnt_r + {31'd0, branch_e};
            mispredict_cnt_r <= mispredict_cnt_r + {31'd0, mispredict_s};
        end
    end

    assign branch_cnt_o     = branch_cnt_r;
    assign mispredict_cnt_o = mispredict_cnt_r;

endmodule

// File: tb/tb_branch_resolve_predictor.sv
// Scoreboard bench for branch_resolve_predictor: driver pushes model expectations,
// a monitor pops and compares them against the DUT outputs every cycle.
module tb_branch_resolve_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_d;
    logic        branch_d;
    logic        predict_o;
    logic        branch_e;
    logic        branch_predict_e;
    logic [31:0] pc_e;
    logic [31:0] rs1_e;
    logic [31:0] rs2_e;
    logic [31:0] pc_notchosen_e;
    logic        flush_o;
    logic [31:0] redirect_pc_o;
    logic        stat_clr;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispredict_cnt_o;

    always #5 clk = ~clk;

    branch_resolve_predictor #(.ENTRIES(16), .IDX_W(4)) dut (
        .clk(clk), .reset(reset), .pc_d(pc_d), .branch_d(branch_d), .predict_o(predict_o),
        .branch_e(branch_e), .branch_predict_e(branch_predict_e), .pc_e(pc_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .pc_notchosen_e(pc_notchosen_e),
        .flush_o(flush_o), .redirect_pc_o(redirect_pc_o), .stat_clr(stat_clr),
        .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
    );

    typedef struct {
        logic        predict;
        logic        flush;
        logic [31:0] redirect;
        logic [31:0] bcnt;
        logic [31:0] mcnt;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: counter strength per table slot (0..3) and plain counts.
    int          m_ctr[16];
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % 32'd16);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ctr[i] = 2;
        m_bcnt = 32'd0;
        m_mcnt = 32'd0;
    endtask

    task automatic step(input logic rst, input logic bd, input logic [31:0] pcd,
                        input logic be, input logic pred, input logic [31:0] pce,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] pnc, input logic clr, input logic wrap);
        exp_t e;
        logic taken;
        logic misp;
        @(negedge clk);
        if (wrap) begin
            force dut.branch_cnt_r = 32'hFFFF_FFFF;
            #1;
            release dut.branch_cnt_r;
            m_bcnt = 32'hFFFF_FFFF;
        end
        reset = rst; branch_d = bd; pc_d = pcd; branch_e = be; branch_predict_e = pred;
        pc_e = pce; rs1_e = r1; rs2_e = r2; pc_notchosen_e = pnc; stat_clr = clr;
        if (!rst) model_reset();
        taken      = (r1 == r2);
        misp       = be && (taken != pred);
        e.predict  = bd && (m_ctr[slot(pcd)] >= 2);
        e.flush    = misp;
        e.redirect = pnc;
        e.bcnt     = m_bcnt;
        e.mcnt     = m_mcnt;
        q.push_back(e);
        if (rst) begin
            if (clr) begin
                m_bcnt = 32'd0;
                m_mcnt = 32'd0;
            end else begin
                m_bcnt = m_bcnt + (be ? 32'd1 : 32'd0);
                m_mcnt = m_mcnt + (misp ? 32'd1 : 32'd0);
            end
            if (be) begin
                if (taken) m_ctr[slot(pce)] = (m_ctr[slot(pce)] == 3) ? 3 : m_ctr[slot(pce)] + 1;
                else       m_ctr[slot(pce)] = (m_ctr[slot(pce)] == 0) ? 0 : m_ctr[slot(pce)] - 1;
            end
        end
    endtask

    task automatic idle(input logic bd, input logic [31:0] pcd);
        step(1'b1, bd, pcd, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (vector %0d, t=%0t)", name, act, exp, vectors, $time);
        end
    endtask

    // Monitor: outputs are always presented, so every cycle with a pending expectation is checked.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                chk("predict_o", {31'd0, predict_o}, {31'd0, e.predict});
                chk("flush_o", {31'd0, flush_o}, {31'd0, e.flush});
                chk("redirect_pc_o", redirect_pc_o, e.redirect);
                chk("branch_cnt_o", branch_cnt_o, e.bcnt);
                chk("mispredict_cnt_o", mispredict_cnt_o, e.mcnt);
            end
        end
    end

    initial begin
        reset = 1'b0; branch_d = 1'b0; pc_d = 32'h0; branch_e = 1'b0; branch_predict_e = 1'b0;
        pc_e = 32'h0; rs1_e = 32'h0; rs2_e = 32'h0; pc_notchosen_e = 32'h0; stat_clr = 1'b0;
        model_reset();

        // Reset state, lookup gating, correct and incorrect resolutions.
        step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        idle(1'b0, 32'h10);
        step(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h10, 32'd5, 32'd5, 32'h99, 1'b0, 1'b0);
        idle(1'b1, 32'h10);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 32'd5, 32'd6, 32'h40, 1'b0, 1'b0);
        idle(1'b1, 32'h10);

        // Saturation toward strong not-taken, neighbour slot untouched.
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h10, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0);
        idle(1'b1, 32'h10);
        idle(1'b1, 32'h14);
        idle(1'b1, 32'h1010);

        // Same-cycle lookup and update: pre-update value, new value next cycle.
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h10, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0);
        idle(1'b1, 32'h10);

        // Counter wrap, clear beating a mispredict, asynchronous reset mid-stream.
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'd3, 32'd4, 32'h80, 1'b0, 1'b1);
        idle(1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'd3, 32'd3, 32'h88, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h24, 32'd3, 32'd4, 32'h90, 1'b1, 1'b0);
        idle(1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'd7, 32'd8, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h10, 32'd7, 32'd8, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Randomized traffic with aliasing PCs and frequent operand equality.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0), 1'($urandom), {24'd0, 6'($urandom), 2'b00},
                 1'($urandom), 1'($urandom), {24'd0, 6'($urandom), 2'b00},
                 32'($urandom_range(0, 2)), 32'($urandom_range(0, 2)), $urandom,
                 ($urandom_range(0, 19) == 0), 1'b0);
        end
        idle(1'b0, 32'h0);

        @(negedge clk);
        #5;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
